// File: rtl/ctrl_pipe_md.sv
// Control pipeline D->E->M->W with stall/bubble/flush handling, plus the
// multiply/divide sequencer that starts, times, stalls and annuls E-stage ops.
module ctrl_pipe_md #(
    parameter int CTRL_W  = 22,
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              md_start_d,
    input  logic              md_div_d,
    input  logic              md_sign_d,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              flush_m,
    input  logic              flush_all,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [CTRL_W-1:0] ctrl_m,
    output logic [CTRL_W-1:0] ctrl_w,
    output logic              md_start,
    output logic              md_div_e,
    output logic              md_sign_e,
    output logic              md_annul,
    output logic              md_stall,
    output logic              md_done
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             start_q;
    logic             hold;
    logic             md_load;

    assign hold    = stall_e | md_stall;
    assign md_load = !flush_all && !hold && !flush_e && md_start_d;

    // NOTE: md_stall feeds hold, which feeds next-state; keeping the outputs in
    // their own process avoids a false combinational loop through one block.
    always_comb begin
        md_stall = 1'b0;
        md_done  = 1'b0;
        if (state == BUSY) begin
            md_stall = (cnt != '0);
            md_done  = (cnt == '0);
        end
    end

    assign md_start = start_q;
    assign md_annul = flush_all && (state == BUSY);

    // E register: hold outranks flush_e so a stalled op is never lost.
    always_ff @(posedge clk) begin
        if (!resetn || flush_all) begin
            ctrl_e    <= '0;
            md_div_e  <= 1'b0;
            md_sign_e <= 1'b0;
        end else if (!hold) begin
            if (flush_e) begin
                ctrl_e    <= '0;
                md_div_e  <= 1'b0;
                md_sign_e <= 1'b0;
            end else begin
                ctrl_e    <= ctrl_d;
                md_div_e  <= md_div_d;
                md_sign_e <= md_sign_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush_all || flush_m || hold) begin
            ctrl_m <= '0;
        end else begin
            ctrl_m <= ctrl_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush_all) begin
            ctrl_w <= '0;
        end else begin
            ctrl_w <= ctrl_m;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the
    // combinational blocks use blocking assignments with defaults first.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            start_q <= md_load;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_all) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (md_load) begin
            state_nxt = BUSY;
            cnt_nxt   = md_div_d ? DIV_CNT : MUL_CNT;
        end else begin
            case (state)
                BUSY: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (hold) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                DONE: begin
                    if (!hold) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_md.sv
// Self-checking bench for ctrl_pipe_md: directed scenarios plus randomized
// traffic against an op-age based behavioural model.
module tb_ctrl_pipe_md;

    localparam int W  = 22;
    localparam int ML = 1;
    localparam int DL = 4;
    localparam int VW = 3 * W + 6;

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] ctrl_d;
    logic         md_start_d, md_div_d, md_sign_d;
    logic         stall_e, flush_e, flush_m, flush_all;
    logic [W-1:0] ctrl_e, ctrl_m, ctrl_w;
    logic         md_start, md_div_e, md_sign_e, md_annul, md_stall, md_done;

    always #5 clk = ~clk;

    ctrl_pipe_md #(.CTRL_W(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .resetn(resetn), .ctrl_d(ctrl_d),
        .md_start_d(md_start_d), .md_div_d(md_div_d), .md_sign_d(md_sign_d),
        .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m), .flush_all(flush_all),
        .ctrl_e(ctrl_e), .ctrl_m(ctrl_m), .ctrl_w(ctrl_w),
        .md_start(md_start), .md_div_e(md_div_e), .md_sign_e(md_sign_e),
        .md_annul(md_annul), .md_stall(md_stall), .md_done(md_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: stage contents plus the age (cycles spent in E) of the md op in E.
    logic [W-1:0] m_e = '0, m_m = '0, m_w = '0;
    logic         m_div = 1'b0, m_sign = 1'b0, m_md = 1'b0;
    int           m_age = 0, m_lat = 1;
    logic         x_start, x_stall, x_done, x_annul;

    always_comb begin
        x_start = m_md && (m_age == 0);
        x_stall = m_md && (m_age < m_lat - 1);
        x_done  = m_md && (m_age == m_lat - 1);
        x_annul = flush_all && m_md && (m_age < m_lat);
    end

    function automatic logic [VW-1:0] dut_vec();
        return {ctrl_e, ctrl_m, ctrl_w, md_start, md_div_e, md_sign_e, md_annul, md_stall, md_done};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_e, m_m, m_w, x_start, m_div, m_sign, x_annul, x_stall, x_done};
    endfunction

    task automatic tick();
        logic hold;
        @(posedge clk);
        hold = stall_e | x_stall;
        if (!resetn || flush_all) m_w = '0; else m_w = m_m;
        if (!resetn || flush_all || flush_m || hold) m_m = '0; else m_m = m_e;
        if (!resetn || flush_all) begin
            m_e = '0; m_div = 1'b0; m_sign = 1'b0; m_md = 1'b0;
        end else if (hold) begin
            if (m_md && m_age < m_lat) m_age++;
        end else if (flush_e) begin
            m_e = '0; m_div = 1'b0; m_sign = 1'b0; m_md = 1'b0;
        end else begin
            m_e = ctrl_d; m_div = md_div_d; m_sign = md_sign_d; m_md = md_start_d;
            m_age = 0; m_lat = md_div_d ? DL : ML;
        end
        #1;
    endtask

    task automatic quiet_inputs();
        ctrl_d = '0; md_start_d = 0; md_div_d = 0; md_sign_d = 0;
        stall_e = 0; flush_e = 0; flush_m = 0; flush_all = 0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        resetn = 0; ctrl_d = '1; md_start_d = 1; md_div_d = 1; md_sign_d = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            n_cmp++;
            if (dut_vec() !== '0) begin
                n_bad++;
                $display("FAIL reset cyc=%0d act=%h exp=0", i, dut_vec());
            end
        end
    endtask

    task automatic test_plain_flow();
        quiet_inputs();
        resetn = 1;
        for (int c = 0; c < 7; c++) begin
            ctrl_d = (c < 3) ? W'(c + 1) : '0;
            #1;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL plain_vec c=%0d act=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (c >= 3 && c <= 5) begin
                n_cmp++;
                if (ctrl_w !== W'(c - 2)) begin
                    n_bad++;
                    $display("FAIL plain_w c=%0d act=%h exp=%h", c, ctrl_w, W'(c - 2));
                end
            end
            tick();
        end
    endtask

    task automatic test_divide();
        logic [W-1:0] d_op = 22'h2A5A5;
        for (int c = 0; c < 8; c++) begin
            int k = c - 2;
            quiet_inputs();
            if (c == 1) begin
                ctrl_d = d_op; md_start_d = 1; md_div_d = 1; md_sign_d = 1;
            end else if (c >= 2) begin
                ctrl_d = W'($urandom);
            end
            #1;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL div_vec k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (k >= 0 && k <= 3) begin
                n_cmp++;
                if ({md_start, md_stall, md_done, md_sign_e} !== {k == 0, k < 3, k == 3, 1'b1}) begin
                    n_bad++;
                    $display("FAIL div_seq k=%0d act=%b exp=%b", k,
                             {md_start, md_stall, md_done, md_sign_e}, {k == 0, k < 3, k == 3, 1'b1});
                end
            end
            if (k >= 0 && k < 3) begin
                n_cmp++;
                if (ctrl_m !== '0) begin
                    n_bad++;
                    $display("FAIL div_bubble k=%0d act=%h exp=0", k, ctrl_m);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (ctrl_m !== d_op) begin
                    n_bad++;
                    $display("FAIL div_to_m act=%h exp=%h", ctrl_m, d_op);
                end
            end
            tick();
        end
    endtask

    task automatic test_annul();
        for (int c = 0; c < 7; c++) begin
            int k = c - 2;
            quiet_inputs();
            if (c == 1) begin
                ctrl_d = 22'h15555; md_start_d = 1; md_div_d = 1;
            end else if (c >= 2) begin
                ctrl_d = W'($urandom);
            end
            flush_all = (k == 2);
            #1;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL annul_vec k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (k == 2) begin
                n_cmp++;
                if (md_annul !== 1'b1) begin
                    n_bad++;
                    $display("FAIL annul_pulse act=%b exp=1", md_annul);
                end
            end
            if (k == 3) begin
                n_cmp++;
                if ({ctrl_e, ctrl_m, ctrl_w, md_stall, md_done, md_annul} !== '0) begin
                    n_bad++;
                    $display("FAIL annul_after act=%h exp=0",
                             {ctrl_e, ctrl_m, ctrl_w, md_stall, md_done, md_annul});
                end
            end
            tick();
        end
    endtask

    task automatic test_ext_stall();
        logic [W-1:0] d_op = 22'h0BEEF;
        for (int c = 0; c < 10; c++) begin
            int k = c - 2;
            quiet_inputs();
            if (c == 1) begin
                ctrl_d = d_op; md_start_d = 1; md_div_d = 1;
            end else if (c >= 2) begin
                ctrl_d = W'($urandom);
            end
            stall_e = (k >= 3 && k <= 5);
            #1;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL xstall_vec k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (k >= 3 && k <= 5) begin
                n_cmp++;
                if ({md_start, md_stall, md_done} !== {2'b00, k == 3}) begin
                    n_bad++;
                    $display("FAIL xstall_seq k=%0d act=%b exp=%b", k,
                             {md_start, md_stall, md_done}, {2'b00, k == 3});
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (ctrl_m !== d_op) begin
                    n_bad++;
                    $display("FAIL xstall_to_m act=%h exp=%h", ctrl_m, d_op);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a_op = 22'h00A11;
        logic [W-1:0] b_op = 22'h00B22;
        for (int c = 0; c < 6; c++) begin
            int k = c - 2;
            quiet_inputs();
            if (c == 1) begin
                ctrl_d = a_op; md_start_d = 1; md_sign_d = 1;
            end else if (c == 2) begin
                ctrl_d = b_op; md_start_d = 1;
            end
            #1;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b_vec k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (k >= 0 && k <= 2) begin
                n_cmp++;
                if ({md_start, md_done, md_stall} !== {k < 2, k < 2, 1'b0}) begin
                    n_bad++;
                    $display("FAIL b2b_seq k=%0d act=%b exp=%b", k,
                             {md_start, md_done, md_stall}, {k < 2, k < 2, 1'b0});
                end
            end
            if (k == 1 || k == 2) begin
                n_cmp++;
                if (ctrl_m !== ((k == 1) ? a_op : b_op)) begin
                    n_bad++;
                    $display("FAIL b2b_order k=%0d act=%h exp=%h", k, ctrl_m,
                             (k == 1) ? a_op : b_op);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            resetn     = ($urandom_range(0, 99) >= 2);
            ctrl_d     = W'($urandom);
            md_start_d = ($urandom_range(0, 99) < 35);
            md_div_d   = $urandom_range(0, 1) == 1;
            md_sign_d  = $urandom_range(0, 1) == 1;
            stall_e    = ($urandom_range(0, 99) < 15);
            flush_e    = ($urandom_range(0, 99) < 10);
            flush_m    = ($urandom_range(0, 99) < 10);
            flush_all  = ($urandom_range(0, 99) < 5);
            #1;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random c=%0d act=%h exp=%h", c, dut_vec(), exp_vec());
            end
            tick();
        end
        resetn = 1;
    endtask

    initial begin
        test_reset();
        test_plain_flow();
        test_divide();
        test_annul();
        test_ext_stall();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_md.md
Name: ctrl_pipe_md

Overview:
- Parametrised control pipeline that follows the main decoder.
- Carries the decoded control bundle from D through E, M and W, with stall, bubble and flush handling.
- Owns the multiply/divide sequencer: issues start, counts a fixed latency, stalls the pipeline while busy, and issues annul on flush.
- Sits between the decoder/controller and the datapath pipeline registers; the hazard unit drives the stall and flush inputs.

Parameters:
- CTRL_W, 22, width of the generic decoded control bundle.
- MUL_LAT, 1, cycles a mult/multu occupies E (>=1).
- DIV_LAT, 32, cycles a div/divu occupies E (>=1).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous reset, active low.
- ctrl_d  in  CTRL_W  decoded control bundle of the instruction in D.
- md_start_d  in  1  instruction in D is mult/multu/div/divu.
- md_div_d  in  1  1 = div/divu, 0 = mult/multu (valid with md_start_d).
- md_sign_d  in  1  1 = signed operation.
- stall_e  in  1  hazard-unit hold of E (and earlier stages).
- flush_e  in  1  insert bubble into E.
- flush_m  in  1  insert bubble into M.
- flush_all  in  1  exception flush; clears E, M and W.
- ctrl_e  out  CTRL_W  E-stage bundle.
- ctrl_m  out  CTRL_W  M-stage bundle.
- ctrl_w  out  CTRL_W  W-stage bundle.
- md_start  out  1  one-cycle start pulse to the mult/div unit.
- md_div_e  out  1  registered md_div_d of the E-stage op.
- md_sign_e  out  1  registered md_sign_d of the E-stage op.
- md_annul  out  1  cancel pulse to the mult/div unit.
- md_stall  out  1  to the hazard unit; holds F/D/E.
- md_done  out  1  last E cycle of the mult/div op.

Behaviour:
- Reset: all outputs 0 at the first clk edge with resetn=0; the sequencer goes to IDLE. No annul pulse is generated by reset.
- Internal hold: hold = stall_e | md_stall.
- E register priority:
  - !resetn or flush_all -> 0.
  - else hold -> keep current value.
  - else flush_e -> 0.
  - else load ctrl_d, md_div_d, md_sign_d.
  - hold has priority over flush_e.
- Load event: an "E load" of a mult/div op is the E register loading with md_start_d=1. Holding an op in E is never a load event.
- M register:
  - !resetn, flush_all or flush_m -> 0.
  - else hold -> 0 (bubble).
  - else load ctrl_e.
- W register: !resetn or flush_all -> 0; else load ctrl_m every cycle.
- Latency: a plain instruction appears in ctrl_e, ctrl_m and ctrl_w 1, 2 and 3 cycles after being presented on ctrl_d with no stall.
- Sequencer states: IDLE, BUSY, DONE. Counter cnt is wide enough for max(MUL_LAT, DIV_LAT)-1; LAT = DIV_LAT if md_div else MUL_LAT.
- E load of a mult/div op (from any state): next state BUSY, cnt <= LAT-1.
  - Cycle E0 (first cycle the op is in E): md_start=1, combinational from a registered flag.
  - The op occupies E for cycles E0 .. E(LAT-1).
- BUSY:
  - md_stall = (cnt != 0); cnt decrements each cycle while nonzero.
  - md_done = (cnt == 0).
  - At cnt==0: next state IDLE if E advances; DONE if stall_e holds E.
- DONE:
  - md_stall=0, md_done=0, no new md_start.
  - Returns to IDLE when E advances (or loads another mult/div op -> BUSY).
- LAT=1: md_start and md_done both asserted in E0; md_stall never asserted. Back-to-back ops start on consecutive cycles.
- Annul: md_annul = flush_all & (state==BUSY), combinational.
  - Next state IDLE, cnt <= 0.
  - flush_all in DONE or IDLE gives no annul.
- Simultaneous flush_all and E load: flush wins; no start, no BUSY.
- md_div_e and md_sign_e follow the E register rules, so they are stable for the whole op.

Test Plan:
- Reset: resetn=0 for 2 cycles with ctrl_d=all ones and md_start_d=1 -> ctrl_e/m/w=0, md_start=md_stall=md_done=md_annul=0.
- Plain flow: ctrl_d=0x00001, 0x00002, 0x00003 on consecutive cycles, no stalls -> ctrl_w shows 1, 2, 3 on cycles 3, 4, 5.
- Divide, DIV_LAT=4: div enters E -> md_start=1 at E0; md_stall=1 for E0..E2; md_done=1 at E3; ctrl_m=0 for those 3 cycles; div bundle appears in ctrl_m at E3+1.
- Annul: div with DIV_LAT=4, flush_all at E2 -> md_annul=1 that cycle; next cycle ctrl_e/m/w=0, md_stall=0, state IDLE.
- External stall, DIV_LAT=4: stall_e=1 during E3 and 2 more cycles -> state DONE; no second md_start; md_stall=0; op moves to M the cycle after stall_e drops.
- Mult, MUL_LAT=1: two mults back-to-back -> md_start and md_done high in 2 consecutive cycles; md_stall stays 0; both bundles reach ctrl_m in order.
